// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for both sides of the async FIFO pointer logic.
//   ADDRSIZE_DEF - default address width (depth = 2**ADDRSIZE_DEF)
//   bin2gray     - binary to reflected Gray code (up to 32 bits)
//   gray2bin     - reflected Gray code to binary (up to 32 bits)
package fifo_pkg;

    localparam int ADDRSIZE_DEF = 8;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_level_if.sv
// wptr_full_level_if: write-side bundle of the FIFO pointer/flag block.
//   winc, wq2_rptr, wclr_ovf        - requests into the block
//   wfull, walmost_full, woverflow  - status flags
//   waddr, wptr, wlevel             - memory address, Gray pointer, fill level
// master = user of the block, slave = the pointer/flag block itself.
interface wptr_full_level_if
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = ADDRSIZE_DEF
);

    logic                winc;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic                wclr_ovf;
    logic                wfull;
    logic                walmost_full;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE:0]   wlevel;
    logic                woverflow;

    modport master (
        output winc, wq2_rptr, wclr_ovf,
        input  wfull, walmost_full, waddr, wptr, wlevel, woverflow
    );

    modport slave (
        input  winc, wq2_rptr, wclr_ovf,
        output wfull, walmost_full, waddr, wptr, wlevel, woverflow
    );

endinterface

// File: rtl/gray2bin_conv.sv
// gray2bin_conv: combinational Gray-to-binary converter (XOR prefix from MSB).
//   gray_i - W-bit Gray code
//   bin_o  - W-bit binary equivalent
module gray2bin_conv #(
    parameter int W = 9
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[W-1:i];
    end

endmodule

// File: rtl/wptr_full_level.sv
// wptr_full_level: write-domain pointer, full/almost-full, fill level and
// sticky overflow for an asynchronous FIFO.
//   wclk   - write clock (the only clock)
//   wrst_n - asynchronous active-low reset
//   wif    - slave side of the write bundle (see wptr_full_level_if)
module wptr_full_level
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = ADDRSIZE_DEF,
    parameter int AFULL_THRESH = 2**ADDRSIZE - 4
) (
    input  logic             wclk,
    input  logic             wrst_n,
    wptr_full_level_if.slave wif
);

    localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE+1)'(AFULL_THRESH);

    logic [ADDRSIZE:0] wbin_q,   wbin_d;
    logic [ADDRSIZE:0] wptr_q,   wptr_d;
    logic [ADDRSIZE:0] wlevel_q, wlevel_d;
    logic              wfull_q,  wfull_d;
    logic              wafull_q, wafull_d;
    logic              wovf_q,   wovf_d;
    logic [ADDRSIZE:0] rbin;

    gray2bin_conv #(.W(ADDRSIZE+1)) u_rconv (
        .gray_i (wif.wq2_rptr),
        .bin_o  (rbin)
    );

    always_comb begin
        wbin_d   = wbin_q + {{ADDRSIZE{1'b0}}, wif.winc & ~wfull_q};
        wptr_d   = (wbin_d >> 1) ^ wbin_d;
        // Full when the write pointer has lapped the read pointer once: in
        // Gray code that is the top two bits inverted, the rest equal.
        wfull_d  = (wptr_d == {~wif.wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                               wif.wq2_rptr[ADDRSIZE-2:0]});
        // Modulo subtraction keeps the level correct across pointer wrap.
        wlevel_d = wbin_d - rbin;
        wafull_d = (wlevel_d >= AFULL_LVL);
        // A new overflow in the same cycle as a clear keeps the flag set.
        wovf_d   = (wif.winc & wfull_q) | (wovf_q & ~wif.wclr_ovf);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

    assign wif.waddr        = wbin_q[ADDRSIZE-1:0];
    assign wif.wptr         = wptr_q;
    assign wif.wlevel       = wlevel_q;
    assign wif.wfull        = wfull_q;
    assign wif.walmost_full = wafull_q;
    assign wif.woverflow    = wovf_q;

endmodule

// File: tb/tb_wptr_full_level.sv
// tb_wptr_full_level: directed scoreboard bench, ADDRSIZE=4, AFULL_THRESH=12.
// The driver pushes the expected post-edge outputs for every cycle it drives;
// a monitor pops and compares one entry after each rising edge, and a second
// monitor handles checks taken between edges (asynchronous reset).
module tb_wptr_full_level;

    typedef struct {
        string name;
        int    full;
        int    afull;
        int    ovf;
        int    waddr;
        int    wptr;
        int    wlevel;
    } exp_t;

    logic wclk = 1'b0;
    logic wrst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    event chk_ev;

    wptr_full_level_if #(.ADDRSIZE(4)) wif ();

    wptr_full_level #(.ADDRSIZE(4), .AFULL_THRESH(12)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .wif    (wif)
    );

    always #5 wclk = ~wclk;

    function automatic int g(input int b);
        return (b ^ (b >> 1)) & 31;
    endfunction

    task automatic cmp(input string tag, input string fld,
                       input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s.%s actual=%0d required=%0d", tag, fld, act, exp);
        end
    endtask

    task automatic check_entry(input exp_t e);
        cmp(e.name, "wfull",        32'(wif.wfull),        e.full);
        cmp(e.name, "walmost_full", 32'(wif.walmost_full), e.afull);
        cmp(e.name, "woverflow",    32'(wif.woverflow),    e.ovf);
        cmp(e.name, "waddr",        32'(wif.waddr),        e.waddr);
        cmp(e.name, "wptr",         32'(wif.wptr),         e.wptr);
        cmp(e.name, "wlevel",       32'(wif.wlevel),       e.wlevel);
    endtask

    // Expectation for the outputs just after the coming rising edge.
    task automatic step(input string name, input int full, input int afull,
                        input int ovf, input int waddr, input int wptr,
                        input int wlevel);
        exp_t e;
        e = '{name, full, afull, ovf, waddr, wptr, wlevel};
        sb_q.push_back(e);
        @(negedge wclk);
    endtask

    // Expectation checked right now, between clock edges.
    task automatic async_chk(input string name);
        exp_t e;
        e = '{name, 0, 0, 0, 0, 0, 0};
        sb_q.push_back(e);
        -> chk_ev;
    endtask

    initial begin
        forever begin
            @(posedge wclk);
            #1;
            if (sb_q.size() > 0) check_entry(sb_q.pop_front());
        end
    end

    initial begin
        forever begin
            @(chk_ev);
            if (sb_q.size() > 0) check_entry(sb_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        wrst_n       = 1'b0;
        wif.winc     = 1'b1;
        wif.wq2_rptr = 5'b00000;
        wif.wclr_ovf = 1'b0;
        #2 async_chk("rst_async0");
        @(negedge wclk);
        step("rst_hold0", 0, 0, 0, 0, 0, 0);
        step("rst_hold1", 0, 0, 0, 0, 0, 0);

        wrst_n   = 1'b1;
        wif.winc = 1'b0;
        step("idle", 0, 0, 0, 0, 0, 0);

        wif.winc = 1'b1;
        for (int k = 1; k <= 16; k++)
            step($sformatf("fill%0d", k), int'(k == 16), int'(k >= 12), 0,
                 k % 16, g(k), k);

        step("wr_full0", 1, 1, 1, 0, 5'b11000, 16);
        step("wr_full1", 1, 1, 1, 0, 5'b11000, 16);
        wif.wclr_ovf = 1'b1;
        step("clr_set_win", 1, 1, 1, 0, 5'b11000, 16);
        wif.winc = 1'b0;
        step("clr", 1, 1, 0, 0, 5'b11000, 16);

        wif.wclr_ovf = 1'b0;
        wif.wq2_rptr = 5'b11000;
        step("rd_adv", 0, 0, 0, 0, 5'b11000, 0);

        wif.winc = 1'b1;
        for (int k = 1; k <= 16; k++)
            step($sformatf("fill2_%0d", k), int'(k == 16), int'(k >= 12), 0,
                 k % 16, g((16 + k) % 32), k);
        step("ovf2", 1, 1, 1, 0, 5'b00000, 16);

        #2 wrst_n = 1'b0;
        #1 async_chk("rst_async1");
        wif.wq2_rptr = 5'b00000;
        @(negedge wclk);
        step("rst_hold2", 0, 0, 0, 0, 0, 0);

        wrst_n   = 1'b1;
        wif.winc = 1'b0;
        step("post_rst_idle", 0, 0, 0, 0, 0, 0);
        wif.winc = 1'b1;
        step("post_rst_wr", 0, 0, 0, 1, 1, 1);
        wif.winc = 1'b0;

        repeat (2) @(negedge wclk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wptr_full_level.md
WPTR_FULL_LEVEL -- requirements
Module: wptr_full_level

Interface
REQ-001 Parameter ADDRSIZE, default 8, SHALL set the address width; FIFO depth = 2**ADDRSIZE.
REQ-002 Parameter AFULL_THRESH, default 2**ADDRSIZE-4, SHALL set the almost-full level; legal range 1..2**ADDRSIZE.
REQ-003 wclk  input  1  SHALL be the write-domain clock; the block SHALL have one clock only.
REQ-004 wrst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 winc  input  1  SHALL be the write request; a write is accepted only when winc=1 and wfull=0.
REQ-006 wq2_rptr  input  ADDRSIZE+1  SHALL be the Gray read pointer, already synchronized into wclk.
REQ-007 wclr_ovf  input  1  SHALL clear the sticky overflow flag.
REQ-008 wfull  output  1  SHALL be the registered full flag.
REQ-009 walmost_full  output  1  SHALL be the registered almost-full flag.
REQ-010 waddr  output  ADDRSIZE  SHALL be the memory write address, wbin[ADDRSIZE-1:0].
REQ-011 wptr  output  ADDRSIZE+1  SHALL be the registered Gray write pointer, for synchronization into the read domain.
REQ-012 wlevel  output  ADDRSIZE+1  SHALL be the registered fill level, 0..2**ADDRSIZE.
REQ-013 woverflow  output  1  SHALL be the sticky flag for a write attempted while full.

Function
REQ-014 wbinnext SHALL be wbin + (winc & ~wfull), modulo 2**(ADDRSIZE+1); wgraynext SHALL be (wbinnext>>1) ^ wbinnext.
REQ-015 wbin and wptr SHALL load wbinnext and wgraynext on every wclk rising edge; waddr SHALL be combinational from wbin.
REQ-016 wfull SHALL register (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}) and rise the cycle after the write that fills the FIFO.
REQ-017 A write while full SHALL leave wbin, wptr and waddr unchanged.
REQ-018 wlevel SHALL register (wbinnext - gray2bin(wq2_rptr)) mod 2**(ADDRSIZE+1).
REQ-019 walmost_full SHALL register (next level >= AFULL_THRESH), so it updates in the same cycle as wlevel.
REQ-020 woverflow SHALL be set the cycle after winc=1 with wfull=1.
REQ-021 woverflow SHALL then hold until a cycle with wclr_ovf=1.
REQ-022 If set and clear occur in the same cycle, set SHALL win.
REQ-023 A read-pointer advance in wq2_rptr SHALL deassert wfull and lower wlevel one cycle later.
REQ-024 Pointer wrap past 2**(ADDRSIZE+1)-1 SHALL be seamless, with no glitch on wfull or wlevel.

Reset
REQ-025 While wrst_n=0, the following SHALL be 0 immediately, independent of wclk: wbin, wptr, waddr, wlevel, wfull, walmost_full and woverflow.
REQ-026 Reset asserted mid-operation (including while full or overflowed) SHALL discard all state; the first write after release SHALL use waddr=0.

Structure
REQ-027 Package fifo_pkg SHALL hold the default ADDRSIZE plus the bin2gray and gray2bin functions shared with the read side.
REQ-028 One sub-module, gray2bin_conv (parameterized XOR-prefix, combinational), SHALL perform wq2_rptr-to-binary conversion; all other logic SHALL be flat in wptr_full_level.

Verification (ADDRSIZE=4, AFULL_THRESH=12)
REQ-029 Reset with winc=1 held -> all outputs 0; after release, first accepted write has waddr=0.
REQ-030 16 writes with wq2_rptr=0 -> cycle after 16th: wfull=1, wptr=5'b11000, wlevel=16, waddr=0.
REQ-031 11 writes -> walmost_full=0, wlevel=11; 12th write -> walmost_full=1, wlevel=12 the next cycle.
REQ-032 winc=1 while full -> wptr holds 5'b11000, woverflow=1 next cycle and stays 1; wclr_ovf=1 with winc=1 -> woverflow stays 1; wclr_ovf=1 with winc=0 -> woverflow=0.
REQ-033 Full state, then wq2_rptr=5'b11000 -> wfull=0, wlevel=0 next cycle; 16 more writes -> wptr=5'b00000, wfull=1.
REQ-034 wrst_n pulsed low asynchronously mid-cycle while wfull=1 and woverflow=1 -> all outputs 0 before the next wclk edge.
